// File: rtl/window3x3_stream.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a column shift
// register, with zero-fill or edge-replicate border handling.
module window3x3_stream #(
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned IMG_W       = 640,
  parameter int unsigned IMG_H       = 480,
  parameter int unsigned BORDER_MODE = 0,
  localparam int unsigned XW         = $clog2(IMG_W),
  localparam int unsigned YW         = $clog2(IMG_H)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic [PIX_W-1:0]   in_pix,
  output logic               win_valid,
  output logic [9*PIX_W-1:0] win_pix,
  output logic [XW-1:0]      out_x,
  output logic [YW-1:0]      out_y,
  output logic               out_border,
  output logic               out_eof,
  output logic               drop_err
);

  localparam int unsigned RW  = $clog2(IMG_H + 2);
  localparam int unsigned CW  = 3 * PIX_W;
  localparam int unsigned WW  = 9 * PIX_W;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  state_e            state_q, state_d;
  logic [XW-1:0]     cx_q, cx_d;
  logic [RW-1:0]     ry_q, ry_d;
  logic              drop_q, drop_d;
  logic [CW-1:0]     s0_q, s0_d, s1_q, s1_d;
  logic [PIX_W-1:0]  rd_a_q, rd_b_q;
  logic [PIX_W-1:0]  mem_a [IMG_W];
  logic [PIX_W-1:0]  mem_b [IMG_W];

  logic              wv_q, wv_d;
  logic [WW-1:0]     wpix_q, wpix_d;
  logic [XW-1:0]     ox_q, ox_d;
  logic [YW-1:0]     oy_q, oy_d;
  logic              ob_q, ob_d;
  logic              oeof_q, oeof_d;

  logic              beat, restart, synth;
  logic [XW-1:0]     bx, cen_x, wr_addr;
  logic [RW-1:0]     by, cen_y;
  logic [PIX_W-1:0]  pix;
  logic [CW-1:0]     cv, col_l, col_m, col_r;
  logic              last_col, emit, top_ok, bot_ok, lft_ok, rgt_ok;

  // Row-direction border fix on one column {bottom, middle, top}
  function automatic logic [CW-1:0] fix_rows(input logic [CW-1:0] c,
                                             input logic t_ok, input logic b_ok);
    logic [PIX_W-1:0] t, m, b;
    t = c[0 +: PIX_W];
    m = c[PIX_W +: PIX_W];
    b = c[2*PIX_W +: PIX_W];
    if (!t_ok) t = (BORDER_MODE != 0) ? m : '0;
    if (!b_ok) b = (BORDER_MODE != 0) ? m : '0;
    return {b, m, t};
  endfunction

  // Frame sequencing: decides whether this cycle carries a beat and of what kind
  always_comb begin
    state_d = state_q;
    beat    = 1'b0;
    restart = 1'b0;
    synth   = 1'b0;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_sof) begin
          beat    = 1'b1;
          restart = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          beat    = 1'b1;
          restart = in_sof;
          if (!in_sof && cx_q == XW'(IMG_W - 1) && ry_q == RW'(IMG_H - 1))
            state_d = FLUSH;
        end
      end
      FLUSH: begin
        beat = 1'b1;
        if (in_valid && in_sof) begin
          restart = 1'b1;
          state_d = RUN;
        end else begin
          synth  = 1'b1;
          drop_d = drop_q | in_valid;
          if (cx_q == '0 && ry_q == RW'(IMG_H + 1))
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat position, window centre and border-masked window assembly
  always_comb begin
    bx       = restart ? '0 : cx_q;
    by       = restart ? '0 : ry_q;
    wr_addr  = bx;
    pix      = synth ? '0 : in_pix;
    cv       = {pix, rd_a_q, rd_b_q};
    last_col = (bx == XW'(IMG_W - 1));
    cx_d     = cx_q;
    ry_d     = ry_q;
    s0_d     = s0_q;
    s1_d     = s1_q;
    if (beat) begin
      cx_d = last_col ? '0 : bx + XW'(1);
      ry_d = last_col ? by + RW'(1) : by;
      s1_d = s0_q;
      s0_d = cv;
    end

    // Window centre trails the beat by one line plus one pixel
    emit   = beat && ((by > RW'(1)) || (by == RW'(1) && bx != '0));
    cen_x  = (bx == '0) ? XW'(IMG_W - 1) : bx - XW'(1);
    cen_y  = (bx == '0) ? by - RW'(2) : by - RW'(1);
    top_ok = (cen_y != '0);
    bot_ok = (cen_y != RW'(IMG_H - 1));
    lft_ok = (cen_x != '0);
    rgt_ok = (cen_x != XW'(IMG_W - 1));

    col_m = fix_rows(s0_q, top_ok, bot_ok);
    col_l = fix_rows(s1_q, top_ok, bot_ok);
    col_r = fix_rows(cv, top_ok, bot_ok);
    if (!lft_ok) col_l = (BORDER_MODE != 0) ? col_m : '0;
    if (!rgt_ok) col_r = (BORDER_MODE != 0) ? col_m : '0;

    wv_d   = 1'b0;
    wpix_d = '0;
    ox_d   = '0;
    oy_d   = '0;
    ob_d   = 1'b0;
    oeof_d = 1'b0;
    if (emit) begin
      wv_d = 1'b1;
      for (int r = 0; r < 3; r++) begin
        wpix_d[(3*r + 0)*PIX_W +: PIX_W] = col_l[r*PIX_W +: PIX_W];
        wpix_d[(3*r + 1)*PIX_W +: PIX_W] = col_m[r*PIX_W +: PIX_W];
        wpix_d[(3*r + 2)*PIX_W +: PIX_W] = col_r[r*PIX_W +: PIX_W];
      end
      ox_d   = cen_x;
      oy_d   = YW'(cen_y);
      ob_d   = !(top_ok && bot_ok && lft_ok && rgt_ok);
      oeof_d = !rgt_ok && !bot_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cx_q    <= '0;
      ry_q    <= '0;
      drop_q  <= 1'b0;
      s0_q    <= '0;
      s1_q    <= '0;
      wv_q    <= 1'b0;
      wpix_q  <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      ob_q    <= 1'b0;
      oeof_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      ry_q    <= ry_d;
      drop_q  <= drop_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      wv_q    <= wv_d;
      wpix_q  <= wpix_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      ob_q    <= ob_d;
      oeof_q  <= oeof_d;
    end
  end

  // Line buffers: reads are prefetched at the next beat's column so the RAM
  // read is registered; rows from a previous frame are masked by position.
  always_ff @(posedge clk) begin
    if (beat) begin
      mem_a[wr_addr] <= pix;
      mem_b[wr_addr] <= rd_a_q;
    end
    rd_a_q <= mem_a[cx_d];
    rd_b_q <= mem_b[cx_d];
  end

  assign win_valid  = wv_q;
  assign win_pix    = wpix_q;
  assign out_x      = ox_q;
  assign out_y      = oy_q;
  assign out_border = ob_q;
  assign out_eof    = oeof_q;
  assign drop_err   = drop_q;

endmodule

// File: tb/tb_window3x3_stream.sv
// Scoreboard bench for window3x3_stream: one DUT per border mode on a shared
// 4x3 stream, expected windows queued at stimulus time and popped by a monitor.
module tb_window3x3_stream;

  localparam int W = 4;
  localparam int H = 3;

  logic clk = 1'b0;
  logic rst, in_valid, in_sof;
  logic [7:0] in_pix;

  logic [1:0]       wv, ob, oe, de;
  logic [1:0][71:0] wp;
  logic [1:0][1:0]  ox, oy;

  typedef struct packed {
    logic [71:0] pix;
    logic [1:0]  x;
    logic [1:0]  y;
    logic        b;
    logic        e;
  } win_t;

  win_t q0[$], q1[$], log0[$], log1[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, first_cyc = 0, last_cyc = 0, beat5_cyc = 0;
  logic mon_en = 1'b0;

  window3x3_stream #(.PIX_W(8), .IMG_W(W), .IMG_H(H), .BORDER_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
    .win_valid(wv[0]), .win_pix(wp[0]), .out_x(ox[0]), .out_y(oy[0]),
    .out_border(ob[0]), .out_eof(oe[0]), .drop_err(de[0]));

  window3x3_stream #(.PIX_W(8), .IMG_W(W), .IMG_H(H), .BORDER_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
    .win_valid(wv[1]), .win_pix(wp[1]), .out_x(ox[1]), .out_y(oy[1]),
    .out_border(ob[1]), .out_eof(oe[1]), .drop_err(de[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] w9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  // Reference window from direct 2D image coordinates; pixel(x,y) = base+y*W+x+1
  function automatic win_t ref_win(input int base, input int c, input int mode);
    win_t w;
    int cx, cy, x, y, v;
    cx = c % W;
    cy = c / W;
    w  = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        x = cx + dx;
        y = cy + dy;
        if (mode == 1) begin
          if (x < 0) x = 0;
          if (x > W - 1) x = W - 1;
          if (y < 0) y = 0;
          if (y > H - 1) y = H - 1;
        end
        if (x < 0 || x >= W || y < 0 || y >= H) v = 0;
        else v = base + y * W + x + 1;
        w.pix[((dy + 1) * 3 + dx + 1) * 8 +: 8] = 8'(v);
      end
    end
    w.x = 2'(cx);
    w.y = 2'(cy);
    w.b = (cx == 0 || cx == W - 1 || cy == 0 || cy == H - 1);
    w.e = (cx == W - 1 && cy == H - 1);
    return w;
  endfunction

  task automatic push_wins(input int base, input int c_lo, input int c_hi);
    for (int c = c_lo; c <= c_hi; c++) begin
      q0.push_back(ref_win(base, c, 0));
      q1.push_back(ref_win(base, c, 1));
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] p);
    @(posedge clk);
    #1;
    in_valid = v;
    in_sof   = s;
    in_pix   = p;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'd0);
  endtask

  task automatic send_frame(input int base, input int nbeats, input bit gaps);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) begin
        for (int g = 0; g < 3; g++)
          if ($urandom_range(0, 1) == 1) drive(1'b0, 1'b0, 8'd0);
      end
      drive(1'b1, i == 0, 8'(base + i + 1));
      if (i == 5) beat5_cyc = cyc + 1;
    end
  endtask

  task automatic new_phase();
    log0.delete();
    log1.delete();
  endtask

  // Monitor: pop and compare on every window, require quiet sideband otherwise
  always @(negedge clk) begin
    win_t got, exp;
    if (mon_en) begin
      for (int m = 0; m < 2; m++) begin
        got = {wp[m], ox[m], oy[m], ob[m], oe[m]};
        if (wv[m]) begin
          if (m == 0) begin
            if (log0.size() == 0) first_cyc = cyc;
            last_cyc = cyc;
            log0.push_back(got);
          end else begin
            log1.push_back(got);
          end
          if ((m == 0 ? q0.size() : q1.size()) == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_window mode%0d: got %h, none expected", m, got);
          end else begin
            exp = (m == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("window_mode%0d", m), 96'(got), 96'(exp));
          end
        end else begin
          chk($sformatf("idle_sideband_mode%0d", m), 96'(got), 96'(0));
        end
      end
    end
  end

  initial begin
    int nb, ok;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pix = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    chk("reset_outputs", 96'({wv, ob, oe, de, wp}), 96'(0));

    // Basic frame, gap-free
    new_phase();
    push_wins(0, 0, 11);
    send_frame(0, 12, 1'b0);
    idle(10);
    chk("basic_count", 96'(log0.size()), 96'(12));
    chk("first_latency", 96'(first_cyc), 96'(beat5_cyc));
    chk("sustained_span", 96'(last_cyc - first_cyc), 96'(11));
    if (log0.size() == 12 && log1.size() == 12) begin
      chk("m0_first", 96'(log0[0].pix), 96'(w9(0, 0, 0, 0, 1, 2, 0, 5, 6)));
      chk("m0_last", 96'(log0[11].pix), 96'(w9(7, 8, 0, 11, 12, 0, 0, 0, 0)));
      chk("m0_last_eof", 96'(log0[11].e), 96'(1));
      chk("m0_centre11", 96'(log0[5].pix), 96'(w9(1, 2, 3, 5, 6, 7, 9, 10, 11)));
      chk("m1_first", 96'(log1[0].pix), 96'(w9(1, 1, 2, 1, 1, 2, 5, 5, 6)));
      chk("m1_centre11", 96'(log1[5].pix), 96'(w9(1, 2, 3, 5, 6, 7, 9, 10, 11)));
      nb = 0;
      for (int i = 0; i < 12; i++) if (!log0[i].b) nb++;
      chk("interior_count", 96'(nb), 96'(2));
      chk("interior_pos", 96'({log0[5].b, log0[6].b}), 96'(0));
    end else begin
      chk("basic_logs", 96'(log1.size()), 96'(99));
    end

    // Same frame with random input gaps
    new_phase();
    push_wins(0, 0, 11);
    send_frame(0, 12, 1'b1);
    idle(10);
    chk("gap_count", 96'(log0.size()), 96'(12));

    // in_sof at beat 7 abandons the frame
    new_phase();
    push_wins(0, 0, 1);
    push_wins(100, 0, 11);
    send_frame(0, 7, 1'b0);
    send_frame(100, 12, 1'b0);
    idle(10);
    chk("abort_count", 96'(log1.size()), 96'(14));
    ok = 1;
    for (int i = 2; i < log1.size(); i++)
      for (int k = 0; k < 9; k++)
        if (log1[i].pix[k*8 +: 8] <= 8'd12) ok = 0;
    chk("abort_no_old_pixels", 96'(ok), 96'(1));

    // Dropped beat during flush, then flush aborted by the next frame
    new_phase();
    chk("drop_err_before", 96'(de), 96'(0));
    push_wins(0, 0, 8);
    push_wins(100, 0, 11);
    send_frame(0, 12, 1'b0);
    drive(1'b1, 1'b0, 8'd99);
    drive(1'b0, 1'b0, 8'd0);
    send_frame(100, 12, 1'b0);
    idle(10);
    chk("drop_err_set", 96'(de), 96'(2'b11));
    chk("drop_window_count", 96'(log0.size()), 96'(21));

    // Reset mid-RUN, then a clean frame
    new_phase();
    push_wins(0, 0, 1);
    send_frame(0, 7, 1'b0);
    chk("drop_err_sticky", 96'(de), 96'(2'b11));
    drive(1'b0, 1'b0, 8'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("post_reset_outputs", 96'({wv, ob, oe, de, wp, ox, oy}), 96'(0));
    idle(8);
    new_phase();
    push_wins(0, 0, 11);
    send_frame(0, 12, 1'b0);
    idle(10);
    chk("post_reset_count", 96'(log0.size()), 96'(12));
    chk("post_reset_drop_err", 96'(de), 96'(0));

    for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) idle(1);
    chk("queues_drained", 96'(q0.size() + q1.size()), 96'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
